vend_ctrl: RTL and testbench
============================

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE, default 15, item price in credit units.
REQ-002 Parameter VAL1, default 5, value of coin code 2'b01 (also the change-coin unit).
REQ-003 Parameter VAL2, default 10, value of coin code 2'b10.
REQ-004 Parameter VAL3, default 25, value of coin code 2'b11.
REQ-005 Parameter CREDIT_W, default 8, credit register width.
REQ-006 Parameter STOCK_W, default 4, stock counter width.
REQ-007 Parameter STOCK_INIT, default 8, stock loaded at reset and restock.
REQ-008 Port clk, input, 1, single clock, rising-edge.
REQ-009 Port reset, input, 1, asynchronous active-high reset.
REQ-010 Port in, input, 2, coin code, sampled each cycle; 2'b00 = no coin.
REQ-011 Port cancel, input, 1, refund request, level-sampled.
REQ-012 Port restock, input, 1, reload stock request.
REQ-013 Port out, output, 1, vend pulse, one cycle per item.
REQ-014 Port change_coin, output, 1, one pulse per VAL1 unit returned.
REQ-015 Port coin_reject, output, 1, registered pulse: coin in the previous cycle was not accepted.
REQ-016 Port sold_out, output, 1, high while stock is zero.
REQ-017 Port credit, output, CREDIT_W, current accumulated credit.
REQ-018 Port pre_s, output, 3, current FSM state encoding.

Function
REQ-019 States SHALL be IDLE=0, COLLECT=1, VEND=2, CHANGE=3, SOLDOUT=4; other encodings SHALL return to IDLE.
REQ-020 IDLE/COLLECT: an accepted coin SHALL add its value to credit next cycle; a nonzero coin moves IDLE to COLLECT.
REQ-021 A coin SHALL be rejected (credit unchanged, coin_reject next cycle) if credit+value exceeds 2^CREDIT_W-1, if the state is VEND, CHANGE or SOLDOUT, or if cancel is high the same cycle.
REQ-022 When registered credit >= PRICE in COLLECT, the FSM SHALL enter VEND; in VEND, out=1 for exactly one cycle, credit -= PRICE, stock -= 1.
REQ-023 After VEND: credit > 0 goes to CHANGE; else stock == 0 goes to SOLDOUT; else IDLE.
REQ-024 CHANGE SHALL assert change_coin one cycle per VAL1 unit, decrementing credit by VAL1 each cycle, exiting to IDLE (or SOLDOUT if stock == 0) when credit reaches 0.
REQ-025 cancel in COLLECT SHALL go to CHANGE with no vend; cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-026 restock SHALL load STOCK_INIT only in IDLE or SOLDOUT; SOLDOUT then returns to IDLE next cycle.
REQ-027 sold_out SHALL equal (stock == 0), registered.
REQ-028 PRICE, VAL2 and VAL3 SHALL be integer multiples of VAL1; an elaboration check SHALL fail otherwise.

Reset
REQ-029 Reset SHALL asynchronously force state IDLE, credit 0, stock STOCK_INIT, and out, change_coin, coin_reject and sold_out to 0.
REQ-030 Reset mid-VEND or mid-CHANGE SHALL abandon the operation; no further pulses SHALL occur after release.

Configuration
REQ-031 Macro VEND_CHANGE_EN defined: behaviour per REQ-023 to REQ-025.
REQ-032 VEND_CHANGE_EN undefined: CHANGE state absent; after VEND, residual credit is retained and the FSM returns to COLLECT (or SOLDOUT); cancel is ignored; change_coin is tied to 0.

Structure
REQ-033 Package vend_pkg SHALL hold the state enum/encodings and the coin-code constants.
REQ-034 Sub-module vend_coin_dec SHALL map the 2-bit code to a CREDIT_W-bit value (combinational).

Verification (defaults; T = the cycle the coin is sampled)
REQ-035 Coins 5 then 10: credit 15 at T+1 after the second coin; out=1 at T+2; credit 0; no change_coin.
REQ-036 Coin 25 with change enabled: one out pulse, then 2 change_coin pulses on consecutive cycles; credit ends 0; stock 7.
REQ-037 Coin 10, then cancel: 2 change_coin pulses, out never high; a coin sent with cancel is rejected.
REQ-038 STOCK_INIT=1: one purchase gives sold_out=1; a following coin gives coin_reject=1; restock clears sold_out and returns the FSM to IDLE.
REQ-039 Assert reset during the first change_coin pulse: all outputs 0 and credit 0 immediately; no pulses after release.
REQ-040 Without VEND_CHANGE_EN, coin 25: out pulse, credit=10 retained; a further coin 5 produces a second out pulse.

Source files
------------

// File: rtl/vend_pkg.sv
// Vending controller shared definitions: FSM state encodings and coin codes.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_VEND    = 3'd2,
    ST_CHANGE  = 3'd3,
    ST_SOLDOUT = 3'd4
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_V1   = 2'b01;
  localparam logic [1:0] COIN_V2   = 2'b10;
  localparam logic [1:0] COIN_V3   = 2'b11;

endpackage

// File: rtl/vend_coin_dec.sv
// Coin code to credit value decoder (purely combinational).
module vend_coin_dec
  import vend_pkg::*;
#(
  parameter int VAL1     = 5,
  parameter int VAL2     = 10,
  parameter int VAL3     = 25,
  parameter int CREDIT_W = 8
) (
  input  logic [1:0]          i_code,
  output logic [CREDIT_W-1:0] o_value
);

  // map coin code to its credit value; no coin is worth nothing
  always_comb begin
    o_value = '0;
    case (i_code)
      COIN_V1: o_value = CREDIT_W'(VAL1);
      COIN_V2: o_value = CREDIT_W'(VAL2);
      COIN_V3: o_value = CREDIT_W'(VAL3);
      default: o_value = '0;
    endcase
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: coin collection, vend, change return, stock.
// Build option: define VEND_CHANGE_EN to enable the CHANGE state, cancel
// refunds and change_coin pulses. Without it residual credit is kept.
//
// state   | meaning
// IDLE    | no credit session, waiting for a coin
// COLLECT | accumulating credit until price reached (or cancel)
// VEND    | one-cycle vend pulse, price and one item deducted
// CHANGE  | return credit one VAL1 unit per cycle
// SOLDOUT | stock empty, coins rejected until restock
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE      = 15,
  parameter int VAL1       = 5,
  parameter int VAL2       = 10,
  parameter int VAL3       = 25,
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          in,
  input  logic                cancel,
  input  logic                restock,
  output logic                out,
  output logic                change_coin,
  output logic                coin_reject,
  output logic                sold_out,
  output logic [CREDIT_W-1:0] credit,
  output logic [2:0]          pre_s
);

  if (((PRICE % VAL1) != 0) || ((VAL2 % VAL1) != 0) || ((VAL3 % VAL1) != 0)) begin : g_bad_values
    $error("vend_ctrl: PRICE, VAL2 and VAL3 must be multiples of VAL1");
  end

  localparam logic [CREDIT_W-1:0] LP_PRICE = CREDIT_W'(PRICE);
`ifdef VEND_CHANGE_EN
  localparam logic [CREDIT_W-1:0] LP_VAL1  = CREDIT_W'(VAL1);
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [STOCK_W-1:0]  r_stock;
  logic [STOCK_W-1:0]  w_stock_nxt;
  logic                r_coin_reject;
  logic                r_sold_out;
  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_credit_after;
  logic                w_has_coin;
  logic                w_open;
  logic                w_accept;
  logic                w_last_item;

  vend_coin_dec #(
    .VAL1     (VAL1),
    .VAL2     (VAL2),
    .VAL3     (VAL3),
    .CREDIT_W (CREDIT_W)
  ) u_coin_dec (
    .i_code  (in),
    .o_value (w_coin_val)
  );

  // coin acceptance: open state, no carry out of the credit register, no cancel
  always_comb begin
    w_sum          = {1'b0, r_credit} + {1'b0, w_coin_val};
    w_has_coin     = (in != COIN_NONE);
    w_open         = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
    w_accept       = w_has_coin && w_open && !cancel && !w_sum[CREDIT_W];
    w_credit_after = r_credit - LP_PRICE;
    w_last_item    = (r_stock <= STOCK_W'(1));
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next-state logic; unknown encodings fall back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
`ifdef VEND_CHANGE_EN
        if (cancel)                     w_state_nxt = ST_CHANGE;
        else if (r_credit >= LP_PRICE)  w_state_nxt = ST_VEND;
`else
        if (r_credit >= LP_PRICE)       w_state_nxt = ST_VEND;
`endif
      end
      ST_VEND: begin
`ifdef VEND_CHANGE_EN
        if (w_credit_after != '0) w_state_nxt = ST_CHANGE;
        else if (w_last_item)     w_state_nxt = ST_SOLDOUT;
        else                      w_state_nxt = ST_IDLE;
`else
        if (w_last_item)               w_state_nxt = ST_SOLDOUT;
        else if (w_credit_after != '0) w_state_nxt = ST_COLLECT;
        else                           w_state_nxt = ST_IDLE;
`endif
      end
`ifdef VEND_CHANGE_EN
      ST_CHANGE: begin
        if (r_credit <= LP_VAL1) w_state_nxt = (r_stock == '0) ? ST_SOLDOUT : ST_IDLE;
      end
`endif
      ST_SOLDOUT: begin
        if (restock) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // credit accumulation, vend deduction and change payout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credit <= '0;
    end else if (w_accept) begin
      r_credit <= w_sum[CREDIT_W-1:0];
    end else if (r_state == ST_VEND) begin
      r_credit <= w_credit_after;
`ifdef VEND_CHANGE_EN
    end else if (r_state == ST_CHANGE) begin
      r_credit <= (r_credit > LP_VAL1) ? (r_credit - LP_VAL1) : '0;
`endif
    end
  end

  // next stock value: decrement on vend, reload only when idle or sold out
  always_comb begin
    w_stock_nxt = r_stock;
    if ((r_state == ST_VEND) && (r_stock != '0))
      w_stock_nxt = r_stock - STOCK_W'(1);
    else if (restock && ((r_state == ST_IDLE) || (r_state == ST_SOLDOUT)))
      w_stock_nxt = STOCK_W'(STOCK_INIT);
  end

  // stock, sold-out flag and coin-reject pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stock       <= STOCK_W'(STOCK_INIT);
      r_sold_out    <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_stock       <= w_stock_nxt;
      r_sold_out    <= (w_stock_nxt == '0);
      r_coin_reject <= w_has_coin && !w_accept;
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    out         = (r_state == ST_VEND);
`ifdef VEND_CHANGE_EN
    change_coin = (r_state == ST_CHANGE) && (r_credit != '0);
`else
    change_coin = 1'b0;
`endif
    coin_reject = r_coin_reject;
    sold_out    = r_sold_out;
    credit      = r_credit;
    pre_s       = r_state;
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl (both VEND_CHANGE_EN builds).
module tb_vend_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] in;
  logic       cancel;
  logic       restock;
  logic       out;
  logic       change_coin;
  logic       coin_reject;
  logic       sold_out;
  logic [7:0] credit;
  logic [2:0] pre_s;

  logic [1:0] in_b;
  logic       cancel_b;
  logic       restock_b;
  logic       out_b;
  logic       change_coin_b;
  logic       coin_reject_b;
  logic       sold_out_b;
  logic [7:0] credit_b;
  logic [2:0] pre_s_b;

  int n_pass;
  int n_total;

  vend_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .cancel      (cancel),
    .restock     (restock),
    .out         (out),
    .change_coin (change_coin),
    .coin_reject (coin_reject),
    .sold_out    (sold_out),
    .credit      (credit),
    .pre_s       (pre_s)
  );

  vend_ctrl #(.STOCK_INIT(1)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .in          (in_b),
    .cancel      (cancel_b),
    .restock     (restock_b),
    .out         (out_b),
    .change_coin (change_coin_b),
    .coin_reject (coin_reject_b),
    .sold_out    (sold_out_b),
    .credit      (credit_b),
    .pre_s       (pre_s_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_total++; if (out !== 1'b0) $display("FAIL reset_out: got %b want 0", out); else n_pass++;
    n_total++; if (change_coin !== 1'b0) $display("FAIL reset_change: got %b want 0", change_coin); else n_pass++;
    n_total++; if (coin_reject !== 1'b0) $display("FAIL reset_reject: got %b want 0", coin_reject); else n_pass++;
    n_total++; if (sold_out !== 1'b0) $display("FAIL reset_sold_out: got %b want 0", sold_out); else n_pass++;
    n_total++; if (credit !== 8'd0) $display("FAIL reset_credit: got %0d want 0", credit); else n_pass++;
    n_total++; if (pre_s !== 3'd0) $display("FAIL reset_state: got %0d want 0", pre_s); else n_pass++;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_total++; if (pre_s !== 3'd0) $display("FAIL reset_release_state: got %0d want 0", pre_s); else n_pass++;
  endtask

  task automatic test_two_coins();
    int n_chg;
    in = 2'b01;
    tick();
    in = 2'b00;
    n_total++; if (credit !== 8'd5) $display("FAIL two_coins_c5: got %0d want 5", credit); else n_pass++;
    n_total++; if (pre_s !== 3'd1) $display("FAIL two_coins_collect: got %0d want 1", pre_s); else n_pass++;
    in = 2'b10;
    tick();
    in = 2'b00;
    n_total++; if (credit !== 8'd15) $display("FAIL two_coins_c15: got %0d want 15", credit); else n_pass++;
    n_total++; if (out !== 1'b0) $display("FAIL two_coins_early_out: got %b want 0", out); else n_pass++;
    tick();
    n_total++; if (out !== 1'b1) $display("FAIL two_coins_out: got %b want 1", out); else n_pass++;
    n_total++; if (pre_s !== 3'd2) $display("FAIL two_coins_vend_state: got %0d want 2", pre_s); else n_pass++;
    in = 2'b01;
    tick();
    in = 2'b00;
    n_total++; if (out !== 1'b0) $display("FAIL two_coins_out_one_cycle: got %b want 0", out); else n_pass++;
    n_total++; if (credit !== 8'd0) $display("FAIL two_coins_credit_end: got %0d want 0", credit); else n_pass++;
    n_total++; if (coin_reject !== 1'b1) $display("FAIL vend_coin_reject: got %b want 1", coin_reject); else n_pass++;
    n_total++; if (pre_s !== 3'd0) $display("FAIL two_coins_idle: got %0d want 0", pre_s); else n_pass++;
    n_chg = 0;
    for (int i = 0; i < 3; i++) begin
      if (change_coin === 1'b1) n_chg++;
      tick();
    end
    n_total++; if (coin_reject !== 1'b0) $display("FAIL reject_clears: got %b want 0", coin_reject); else n_pass++;
    n_total++; if (n_chg !== 0) $display("FAIL two_coins_no_change: got %0d want 0", n_chg); else n_pass++;
  endtask

  task automatic test_big_coin();
    in = 2'b11;
    tick();
    in = 2'b00;
    n_total++; if (credit !== 8'd25) $display("FAIL big_c25: got %0d want 25", credit); else n_pass++;
    tick();
    n_total++; if (out !== 1'b1) $display("FAIL big_out: got %b want 1", out); else n_pass++;
    tick();
    n_total++; if (out !== 1'b0) $display("FAIL big_out_end: got %b want 0", out); else n_pass++;
    n_total++; if (credit !== 8'd10) $display("FAIL big_residual: got %0d want 10", credit); else n_pass++;
`ifdef VEND_CHANGE_EN
    n_total++; if (pre_s !== 3'd3) $display("FAIL big_change_state: got %0d want 3", pre_s); else n_pass++;
    n_total++; if (change_coin !== 1'b1) $display("FAIL big_change1: got %b want 1", change_coin); else n_pass++;
    tick();
    n_total++; if (change_coin !== 1'b1) $display("FAIL big_change2: got %b want 1", change_coin); else n_pass++;
    n_total++; if (credit !== 8'd5) $display("FAIL big_change2_credit: got %0d want 5", credit); else n_pass++;
    tick();
    n_total++; if (change_coin !== 1'b0) $display("FAIL big_change_end: got %b want 0", change_coin); else n_pass++;
    n_total++; if (credit !== 8'd0) $display("FAIL big_credit_end: got %0d want 0", credit); else n_pass++;
    n_total++; if (pre_s !== 3'd0) $display("FAIL big_idle: got %0d want 0", pre_s); else n_pass++;
`else
    n_total++; if (pre_s !== 3'd1) $display("FAIL big_collect: got %0d want 1", pre_s); else n_pass++;
    in = 2'b01;
    tick();
    in = 2'b00;
    n_total++; if (credit !== 8'd15) $display("FAIL big_c15: got %0d want 15", credit); else n_pass++;
    tick();
    n_total++; if (out !== 1'b1) $display("FAIL big_second_out: got %b want 1", out); else n_pass++;
    tick();
    n_total++; if (credit !== 8'd0) $display("FAIL big_credit_end: got %0d want 0", credit); else n_pass++;
    n_total++; if (pre_s !== 3'd0) $display("FAIL big_idle: got %0d want 0", pre_s); else n_pass++;
    n_total++; if (change_coin !== 1'b0) $display("FAIL big_no_change: got %b want 0", change_coin); else n_pass++;
`endif
  endtask

  task automatic test_cancel();
    in = 2'b10;
    tick();
    in = 2'b00;
    n_total++; if (credit !== 8'd10) $display("FAIL cancel_c10: got %0d want 10", credit); else n_pass++;
    in = 2'b01;
    cancel = 1'b1;
    tick();
    in = 2'b00;
    cancel = 1'b0;
    n_total++; if (coin_reject !== 1'b1) $display("FAIL cancel_coin_reject: got %b want 1", coin_reject); else n_pass++;
    n_total++; if (credit !== 8'd10) $display("FAIL cancel_credit_kept: got %0d want 10", credit); else n_pass++;
`ifdef VEND_CHANGE_EN
    begin
      int n_chg;
      int n_out;
      n_total++; if (pre_s !== 3'd3) $display("FAIL cancel_change_state: got %0d want 3", pre_s); else n_pass++;
      n_chg = 0;
      n_out = 0;
      for (int i = 0; i < 5; i++) begin
        if (change_coin === 1'b1) n_chg++;
        if (out === 1'b1) n_out++;
        tick();
      end
      n_total++; if (n_chg !== 2) $display("FAIL cancel_change_pulses: got %0d want 2", n_chg); else n_pass++;
      n_total++; if (n_out !== 0) $display("FAIL cancel_no_vend: got %0d want 0", n_out); else n_pass++;
      n_total++; if (credit !== 8'd0) $display("FAIL cancel_credit_end: got %0d want 0", credit); else n_pass++;
    end
`else
    n_total++; if (pre_s !== 3'd1) $display("FAIL cancel_ignored_state: got %0d want 1", pre_s); else n_pass++;
    in = 2'b01;
    tick();
    in = 2'b00;
    tick();
    n_total++; if (out !== 1'b1) $display("FAIL cancel_then_vend: got %b want 1", out); else n_pass++;
    tick();
    n_total++; if (credit !== 8'd0) $display("FAIL cancel_credit_end: got %0d want 0", credit); else n_pass++;
`endif
  endtask

  task automatic test_soldout();
    in_b = 2'b01;
    tick();
    in_b = 2'b10;
    tick();
    in_b = 2'b00;
    tick();
    n_total++; if (out_b !== 1'b1) $display("FAIL so_out: got %b want 1", out_b); else n_pass++;
    n_total++; if (sold_out_b !== 1'b0) $display("FAIL so_before_vend: got %b want 0", sold_out_b); else n_pass++;
    tick();
    n_total++; if (sold_out_b !== 1'b1) $display("FAIL so_flag: got %b want 1", sold_out_b); else n_pass++;
    n_total++; if (pre_s_b !== 3'd4) $display("FAIL so_state: got %0d want 4", pre_s_b); else n_pass++;
    in_b = 2'b01;
    tick();
    in_b = 2'b00;
    n_total++; if (coin_reject_b !== 1'b1) $display("FAIL so_coin_reject: got %b want 1", coin_reject_b); else n_pass++;
    n_total++; if (credit_b !== 8'd0) $display("FAIL so_credit: got %0d want 0", credit_b); else n_pass++;
    restock_b = 1'b1;
    tick();
    restock_b = 1'b0;
    n_total++; if (sold_out_b !== 1'b0) $display("FAIL so_restock_flag: got %b want 0", sold_out_b); else n_pass++;
    n_total++; if (pre_s_b !== 3'd0) $display("FAIL so_restock_idle: got %0d want 0", pre_s_b); else n_pass++;
    n_total++; if (change_coin_b !== 1'b0) $display("FAIL so_no_change: got %b want 0", change_coin_b); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n_pulse;
    in = 2'b11;
    tick();
    in = 2'b00;
    tick();
`ifdef VEND_CHANGE_EN
    tick();
    n_total++; if (change_coin !== 1'b1) $display("FAIL mid_first_change: got %b want 1", change_coin); else n_pass++;
`else
    n_total++; if (out !== 1'b1) $display("FAIL mid_vend: got %b want 1", out); else n_pass++;
`endif
    #2;
    reset = 1'b1;
    #1;
    n_total++; if ({out, change_coin, coin_reject, sold_out} !== 4'b0000)
      $display("FAIL mid_outputs: got %b want 0000", {out, change_coin, coin_reject, sold_out}); else n_pass++;
    n_total++; if (credit !== 8'd0) $display("FAIL mid_credit: got %0d want 0", credit); else n_pass++;
    n_total++; if (pre_s !== 3'd0) $display("FAIL mid_state: got %0d want 0", pre_s); else n_pass++;
    tick();
    reset = 1'b0;
    n_pulse = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out === 1'b1 || change_coin === 1'b1) n_pulse++;
    end
    n_total++; if (n_pulse !== 0) $display("FAIL mid_no_pulses: got %0d want 0", n_pulse); else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b0;
    in        = 2'b00;
    cancel    = 1'b0;
    restock   = 1'b0;
    in_b      = 2'b00;
    cancel_b  = 1'b0;
    restock_b = 1'b0;
    test_reset();
    test_two_coins();
    test_big_coin();
    test_cancel();
    test_soldout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
